// File: rtl/rgb_led_scheduler_pkg.sv
// Shared types and widths for the RGB LED slot scheduler.
// Holds the FSM state encoding and the field widths used by the top and the arbiter.
package rgb_led_scheduler_pkg;

  localparam int COLOR_W = 3;
  localparam int TICK_W  = 16;
  localparam int PWM_W   = 8;
  localparam int PTR_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Converts a one-hot grant (up to four requesters) into its index.
  function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [3:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = PTR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rgb_led_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first requester after the last granted index,
// wrapping to index 0; purely combinational, one-hot grant out.
module rr_arbiter
  import rgb_led_scheduler_pkg::*;
#(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] last_ptr_i,
  output logic [N_REQ-1:0] gnt_o
);

  logic found;

  // First pass covers indices above the pointer, second pass wraps from index 0.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_i[i] && (i > int'(last_ptr_i))) begin
        gnt_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_i[i]) begin
        gnt_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rgb_led_scheduler.sv
// Time-slices one RGB LED between N_REQ requesters: round-robin grant, a hold of
// N ticks with PWM-dimmed colour, then a one-tick dark gap before the next grant.
module rgb_led_scheduler
  import rgb_led_scheduler_pkg::*;
#(
  parameter int CLK_HZ  = 12000000,
  parameter int TICK_HZ = 1000,
  parameter int N_REQ   = 3
) (
  input  logic                     clock_12mhz,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [COLOR_W*N_REQ-1:0] req_color,
  input  logic [TICK_W*N_REQ-1:0]  req_ticks,
  input  logic [PWM_W-1:0]         brightness,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         done,
  output logic                     busy,
  output logic                     led_red,
  output logic                     led_green,
  output logic                     led_blue
);

  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);

  logic [1:0]         rst_sync_q;
  logic               rst_n_int;

  state_e             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [TICK_W-1:0]  ticks_q, ticks_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic [PTR_W-1:0]   last_ptr_q, last_ptr_d;
  logic [PWM_W-1:0]   pwm_cnt_q;
  logic [COLOR_W-1:0] led_q, led_d;

  logic [N_REQ-1:0]   arb_gnt;
  logic [COLOR_W-1:0] sel_color;
  logic [TICK_W-1:0]  sel_ticks;
  logic               presc_wrap;
  logic               slot_end;
  logic               pwm_on;

  // Assertion is immediate through the flop clears; release waits two edges.
  always_ff @(posedge clock_12mhz or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n_int = rst_sync_q[1];

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_rr_arbiter (
    .req_i      (req),
    .last_ptr_i (last_ptr_q),
    .gnt_o      (arb_gnt)
  );

  always_comb begin
    sel_color = '0;
    sel_ticks = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_color = req_color[i*COLOR_W +: COLOR_W];
        sel_ticks = req_ticks[i*TICK_W +: TICK_W];
      end
    end
  end

  assign presc_wrap = (presc_q == PRESC_LAST);

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    tick_cnt_d = tick_cnt_q;
    ticks_d    = ticks_q;
    color_d    = color_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    last_ptr_d = last_ptr_q;
    slot_end   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d    = ST_HOLD;
          gnt_d      = arb_gnt;
          color_d    = sel_color;
          ticks_d    = (sel_ticks == '0) ? TICK_W'(1) : sel_ticks;
          last_ptr_d = onehot_to_idx(4'(arb_gnt));
          presc_d    = '0;
          tick_cnt_d = '0;
        end
      end

      ST_HOLD: begin
        // A dropped request ends the slot at once, regardless of the tick count.
        if ((req & gnt_q) == '0) begin
          slot_end = 1'b1;
        end else if (presc_wrap) begin
          if (tick_cnt_q == ticks_q - TICK_W'(1)) slot_end = 1'b1;
          else                                    tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end
        presc_d = presc_wrap ? '0 : presc_q + PRESC_W'(1);
        if (slot_end) begin
          state_d    = ST_GAP;
          done_d     = gnt_q;
          gnt_d      = '0;
          presc_d    = '0;
          tick_cnt_d = '0;
        end
      end

      ST_GAP: begin
        if (presc_wrap) begin
          state_d = ST_IDLE;
          presc_d = '0;
        end else begin
          presc_d = presc_q + PRESC_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Full brightness bypasses the compare so 255 means always on, not 255/256.
  assign pwm_on = (brightness == '1) || (pwm_cnt_q < brightness);
  assign led_d  = ((state_q == ST_HOLD) && pwm_on) ? color_q : '0;

  always_ff @(posedge clock_12mhz or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      tick_cnt_q <= '0;
      ticks_q    <= '0;
      color_q    <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      last_ptr_q <= PTR_W'(N_REQ - 1);
      pwm_cnt_q  <= '0;
      led_q      <= '0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      tick_cnt_q <= tick_cnt_d;
      ticks_q    <= ticks_d;
      color_q    <= color_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      last_ptr_q <= last_ptr_d;
      pwm_cnt_q  <= pwm_cnt_q + PWM_W'(1);
      led_q      <= led_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign busy      = (state_q != ST_IDLE);
  assign led_red   = led_q[0];
  assign led_green = led_q[1];
  assign led_blue  = led_q[2];

endmodule

// File: tb/tb_rgb_led_scheduler.sv
// Scoreboard bench for rgb_led_scheduler at 10 clocks per tick: a monitor turns each
// observed slot into a record, and each test compares those against expected records.
module tb_rgb_led_scheduler;

  logic        clock_12mhz = 1'b0;
  logic        reset_n;
  logic [2:0]  req;
  logic [8:0]  req_color;
  logic [47:0] req_ticks;
  logic [7:0]  brightness;
  logic [2:0]  gnt;
  logic [2:0]  done;
  logic        busy;
  logic        led_red;
  logic        led_green;
  logic        led_blue;

  typedef struct packed {
    logic [2:0]  gnt;
    logic [15:0] hold;
    logic [15:0] red;
    logic [15:0] green;
    logic [15:0] blue;
    logic [2:0]  done;
  } slot_t;

  slot_t exp_q[$];
  slot_t obs_q[$];
  int    gap_q[$];
  slot_t cur;
  bit    in_slot;
  bit    in_gap;
  int    gap_len;
  int    stray_cnt;
  int    done_total;
  int    errors;
  int    checks;

  rgb_led_scheduler #(
    .CLK_HZ (100),
    .TICK_HZ(10),
    .N_REQ  (3)
  ) dut (
    .clock_12mhz(clock_12mhz),
    .reset_n    (reset_n),
    .req        (req),
    .req_color  (req_color),
    .req_ticks  (req_ticks),
    .brightness (brightness),
    .gnt        (gnt),
    .done       (done),
    .busy       (busy),
    .led_red    (led_red),
    .led_green  (led_green),
    .led_blue   (led_blue)
  );

  always #5 clock_12mhz = ~clock_12mhz;

  // Monitor: a slot spans the cycles with gnt set plus the done cycle after it,
  // since the registered LEDs still show the last hold cycle there.
  initial begin
    in_slot = 1'b0; in_gap = 1'b0; gap_len = 0; stray_cnt = 0; done_total = 0;
    cur = '0;
    forever begin
      @(negedge clock_12mhz);
      if (!reset_n) begin
        in_slot = 1'b0;
        in_gap  = 1'b0;
      end else begin
        if (done !== 3'b000) done_total++;
        if (gnt !== 3'b000) begin
          if (!in_slot) begin
            in_slot  = 1'b1;
            cur      = '0;
            cur.gnt  = gnt;
          end
          cur.hold  = cur.hold + 16'd1;
          cur.red   = cur.red + {15'd0, led_red};
          cur.green = cur.green + {15'd0, led_green};
          cur.blue  = cur.blue + {15'd0, led_blue};
          if (!$onehot(gnt)) stray_cnt++;
        end else if (in_slot) begin
          cur.red   = cur.red + {15'd0, led_red};
          cur.green = cur.green + {15'd0, led_green};
          cur.blue  = cur.blue + {15'd0, led_blue};
          cur.done  = done;
          obs_q.push_back(cur);
          in_slot = 1'b0;
          in_gap  = 1'b1;
          gap_len = 0;
        end
        if (in_gap) begin
          if (busy && gnt == 3'b000) gap_len++;
          else begin
            gap_q.push_back(gap_len);
            in_gap = 1'b0;
          end
        end
        if ((led_red | led_green | led_blue) && gnt == 3'b000 && done == 3'b000) stray_cnt++;
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(negedge clock_12mhz);
    #1;
  endtask

  task automatic wait_records(input int n, input int budget, output bit ok);
    int c;
    c = 0;
    while (obs_q.size() < n && c < budget) begin
      step();
      c++;
    end
    ok = (obs_q.size() >= n);
  endtask

  task automatic wait_gaps(input int n, input int budget, output bit ok);
    int c;
    c = 0;
    while (gap_q.size() < n && c < budget) begin
      step();
      c++;
    end
    ok = (gap_q.size() >= n);
  endtask

  function automatic slot_t mk(input logic [2:0] g, input int h, input int r,
                               input int gr, input int b, input logic [2:0] d);
    slot_t s;
    s.gnt = g; s.hold = 16'(h); s.red = 16'(r); s.green = 16'(gr); s.blue = 16'(b); s.done = d;
    return s;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; req = '0; req_color = '0; req_ticks = '0; brightness = '0;
    repeat (3) step();
    checks++;
    if (gnt !== 3'b000) begin errors++; $display("[TB] FAIL reset_gnt got=%b want=000", gnt); end
    checks++;
    if (done !== 3'b000) begin errors++; $display("[TB] FAIL reset_done got=%b want=000", done); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    checks++;
    if ({led_blue, led_green, led_red} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_leds got=%b want=000", {led_blue, led_green, led_red});
    end
    reset_n = 1'b1;
    repeat (4) step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_contention();
    slot_t e, o;
    bit ok;
    int g;
    obs_q.delete(); gap_q.delete(); exp_q.delete();
    req_color = {3'b100, 3'b010, 3'b001};
    req_ticks = {16'd1, 16'd1, 16'd1};
    brightness = 8'd255;
    exp_q.push_back(mk(3'b001, 10, 10, 0, 0, 3'b001));
    exp_q.push_back(mk(3'b010, 10, 0, 10, 0, 3'b010));
    exp_q.push_back(mk(3'b100, 10, 0, 0, 10, 3'b100));
    exp_q.push_back(mk(3'b001, 10, 10, 0, 0, 3'b001));
    req = 3'b111;
    wait_records(4, 300, ok);
    req = 3'b000;
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL contention_timeout got=%0d slots want=4", obs_q.size()); end
    wait_gaps(4, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL contention_gap_timeout got=%0d gaps want=4", gap_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("[TB] FAIL contention_slot missing, want gnt=%b", e.gnt);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("[TB] FAIL contention_slot got gnt=%b hold=%0d rgb=%0d/%0d/%0d done=%b want gnt=%b hold=%0d rgb=%0d/%0d/%0d done=%b",
                   o.gnt, o.hold, o.red, o.green, o.blue, o.done, e.gnt, e.hold, e.red, e.green, e.blue, e.done);
        end
      end
    end
    while (gap_q.size() > 0) begin
      g = gap_q.pop_front();
      checks++;
      if (g !== 10) begin errors++; $display("[TB] FAIL contention_gap got=%0d want=10", g); end
    end
  endtask

  task automatic test_single();
    slot_t e, o;
    bit ok;
    int g;
    obs_q.delete(); gap_q.delete(); exp_q.delete();
    req_color = 9'b000_000_001;
    req_ticks = {16'd0, 16'd0, 16'd3};
    brightness = 8'd255;
    exp_q.push_back(mk(3'b001, 30, 30, 0, 0, 3'b001));
    req = 3'b001;
    step();
    checks++;
    if (gnt !== 3'b001) begin errors++; $display("[TB] FAIL single_grant_latency got=%b want=001", gnt); end
    // Latched colour and length must not follow these mid-slot changes.
    req_color = 9'b000_000_110;
    req_ticks = {16'd0, 16'd0, 16'd1};
    wait_records(1, 100, ok);
    req = 3'b000;
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL single_timeout got=%0d slots want=1", obs_q.size()); end
    wait_gaps(1, 50, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL single_gap_timeout got=%0d gaps want=1", gap_q.size()); end
    checks++;
    if (busy !== 1'b0 || gnt !== 3'b000) begin
      errors++; $display("[TB] FAIL single_idle got busy=%b gnt=%b want busy=0 gnt=000", busy, gnt);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("[TB] FAIL single_slot missing, want gnt=%b", e.gnt);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("[TB] FAIL single_slot got gnt=%b hold=%0d rgb=%0d/%0d/%0d done=%b want gnt=%b hold=%0d rgb=%0d/%0d/%0d done=%b",
                   o.gnt, o.hold, o.red, o.green, o.blue, o.done, e.gnt, e.hold, e.red, e.green, e.blue, e.done);
        end
      end
    end
    while (gap_q.size() > 0) begin
      g = gap_q.pop_front();
      checks++;
      if (g !== 10) begin errors++; $display("[TB] FAIL single_gap got=%0d want=10", g); end
    end
  endtask

  task automatic test_early_release();
    slot_t e, o;
    bit ok;
    obs_q.delete(); gap_q.delete(); exp_q.delete();
    req_color = 9'b000_000_001;
    req_ticks = {16'd0, 16'd0, 16'd5};
    brightness = 8'd255;
    exp_q.push_back(mk(3'b001, 12, 12, 0, 0, 3'b001));
    req = 3'b001;
    step();
    repeat (11) step();
    req = 3'b000;
    step();
    checks++;
    if (done !== 3'b001 || gnt !== 3'b000 || busy !== 1'b1) begin
      errors++; $display("[TB] FAIL early_end got done=%b gnt=%b busy=%b want done=001 gnt=000 busy=1", done, gnt, busy);
    end
    step();
    checks++;
    if ({led_blue, led_green, led_red} !== 3'b000 || done !== 3'b000) begin
      errors++; $display("[TB] FAIL early_gap got leds=%b done=%b want leds=000 done=000", {led_blue, led_green, led_red}, done);
    end
    wait_records(1, 10, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL early_timeout got=%0d slots want=1", obs_q.size()); end
    wait_gaps(1, 50, ok);
    checks++;
    if (!ok || gap_q[0] !== 10) begin
      errors++; $display("[TB] FAIL early_gap_len got=%0d want=10", ok ? gap_q[0] : -1);
    end
    e = exp_q.pop_front();
    checks++;
    if (obs_q.size() == 0) begin
      errors++; $display("[TB] FAIL early_slot missing, want gnt=%b", e.gnt);
    end else begin
      o = obs_q.pop_front();
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL early_slot got gnt=%b hold=%0d red=%0d done=%b want gnt=%b hold=%0d red=%0d done=%b",
                 o.gnt, o.hold, o.red, o.done, e.gnt, e.hold, e.red, e.done);
      end
    end
  endtask

  task automatic test_pwm();
    slot_t e, o;
    bit ok;
    int green_cnt, red_cnt;
    obs_q.delete(); gap_q.delete(); exp_q.delete();
    req_color = 9'b000_000_010;
    req_ticks = {16'd0, 16'd0, 16'd100};
    brightness = 8'd64;
    exp_q.push_back(mk(3'b001, 365, 0, 0, 0, 3'b001));
    req = 3'b001;
    step();
    repeat (5) step();
    green_cnt = 0; red_cnt = 0;
    repeat (256) begin
      step();
      green_cnt += int'(led_green);
      red_cnt += int'(led_red);
    end
    checks++;
    if (green_cnt !== 64) begin errors++; $display("[TB] FAIL pwm_duty64 got=%0d want=64", green_cnt); end
    checks++;
    if (red_cnt !== 0) begin errors++; $display("[TB] FAIL pwm_red_off got=%0d want=0", red_cnt); end
    brightness = 8'd0;
    repeat (3) step();
    green_cnt = 0;
    repeat (100) begin
      step();
      green_cnt += int'(led_green);
    end
    checks++;
    if (green_cnt !== 0) begin errors++; $display("[TB] FAIL pwm_duty0 got=%0d want=0", green_cnt); end
    req = 3'b000;
    wait_records(1, 10, ok);
    wait_gaps(1, 50, ok);
    e = exp_q.pop_front();
    checks++;
    if (obs_q.size() == 0) begin
      errors++; $display("[TB] FAIL pwm_slot missing, want gnt=%b", e.gnt);
    end else begin
      o = obs_q.pop_front();
      if (o.gnt !== e.gnt || o.hold !== e.hold || o.done !== e.done) begin
        errors++;
        $display("[TB] FAIL pwm_slot got gnt=%b hold=%0d done=%b want gnt=%b hold=%0d done=%b",
                 o.gnt, o.hold, o.done, e.gnt, e.hold, e.done);
      end
    end
  endtask

  task automatic test_zero_ticks();
    slot_t e, o;
    bit ok;
    obs_q.delete(); gap_q.delete(); exp_q.delete();
    req_color = 9'b000_111_000;
    req_ticks = {16'd0, 16'd0, 16'd0};
    brightness = 8'd255;
    exp_q.push_back(mk(3'b010, 10, 10, 10, 10, 3'b010));
    req = 3'b010;
    wait_records(1, 100, ok);
    req = 3'b000;
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL zero_ticks_timeout got=%0d slots want=1", obs_q.size()); end
    wait_gaps(1, 50, ok);
    e = exp_q.pop_front();
    checks++;
    if (obs_q.size() == 0) begin
      errors++; $display("[TB] FAIL zero_ticks_slot missing, want gnt=%b", e.gnt);
    end else begin
      o = obs_q.pop_front();
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL zero_ticks_slot got gnt=%b hold=%0d rgb=%0d/%0d/%0d done=%b want gnt=%b hold=%0d rgb=%0d/%0d/%0d done=%b",
                 o.gnt, o.hold, o.red, o.green, o.blue, o.done, e.gnt, e.hold, e.red, e.green, e.blue, e.done);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    slot_t e, o;
    bit ok;
    int done_before;
    obs_q.delete(); gap_q.delete(); exp_q.delete();
    req_color = 9'b000_000_111;
    req_ticks = {16'd0, 16'd0, 16'd5};
    brightness = 8'd255;
    req = 3'b001;
    step();
    repeat (6) step();
    done_before = done_total;
    reset_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 3'b000 || done !== 3'b000 || busy !== 1'b0 || {led_blue, led_green, led_red} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL abort_outputs got gnt=%b done=%b busy=%b leds=%b want all zero",
               gnt, done, busy, {led_blue, led_green, led_red});
    end
    // Requester 0 held the aborted slot; a kept pointer would now favour requester 1.
    req = 3'b011;
    req_color = 9'b000_010_111;
    req_ticks = {16'd0, 16'd1, 16'd1};
    repeat (3) step();
    reset_n = 1'b1;
    exp_q.push_back(mk(3'b001, 10, 10, 10, 10, 3'b001));
    exp_q.push_back(mk(3'b010, 10, 0, 10, 0, 3'b010));
    wait_records(2, 200, ok);
    req = 3'b000;
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL abort_timeout got=%0d slots want=2", obs_q.size()); end
    checks++;
    if (obs_q.size() > 0 && obs_q[0].gnt !== 3'b001) begin
      errors++; $display("[TB] FAIL abort_pointer got first gnt=%b want=001", obs_q[0].gnt);
    end
    checks++;
    if (done_total - done_before !== 2) begin
      errors++; $display("[TB] FAIL abort_done_pulses got=%0d want=2", done_total - done_before);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("[TB] FAIL abort_slot missing, want gnt=%b", e.gnt);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("[TB] FAIL abort_slot got gnt=%b hold=%0d rgb=%0d/%0d/%0d done=%b want gnt=%b hold=%0d rgb=%0d/%0d/%0d done=%b",
                   o.gnt, o.hold, o.red, o.green, o.blue, o.done, e.gnt, e.hold, e.red, e.green, e.blue, e.done);
        end
      end
    end
    wait_gaps(2, 50, ok);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    $display("[TB] start");
    test_reset();
    test_contention();
    test_single();
    test_early_release();
    test_pwm();
    test_zero_ticks();
    test_reset_mid_hold();
    checks++;
    if (stray_cnt !== 0) begin errors++; $display("[TB] FAIL stray_leds_or_grant got=%0d want=0", stray_cnt); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
